spi_command_master: RTL and testbench
=====================================

// Module: spi_command_master
// PURPOSE
// - SPI initiator that drives the sprite/colour/misc SPI command port from an on-chip byte stream.
// - Serves as a bring-up driver and as the bench-side transmitter for the SPI receiver.
// - Mode CPOL=0, CPHA=1, MSB first, 8-bit words, CS active low.
// - Multi-byte commands share one CS-low frame; an optional MISO path captures readback.
// PARAMETERS
// - CLK_DIV   4  clk cycles per SCLK half-period; range 4..255 (receiver syncs SCLK through 2 FFs)
// - CS_SETUP  2  clk cycles CS low before the first SCLK rising edge; range 1..255
// - CS_HOLD   2  clk cycles CS stays low after the last falling edge; also minimum CS-high idle time; range 1..255
// PORTS
// - clk       in   1  system clock
// - reset_n   in   1  async active-low reset
// - tx_valid  in   1  byte available
// - tx_ready  out  1  byte accepted when tx_valid && tx_ready
// - tx_data   in   8  byte to send, MSB first
// - tx_last   in   1  qualifies tx_data; byte ends the CS frame
// - rx_valid  out  1  1-clk pulse: rx_data holds the byte captured during the last word
// - rx_data   out  8  MISO byte, MSB first
// - busy      out  1  high in every state except IDLE
// - spi_sclk  out  1  SPI clock, idles low
// - spi_mosi  out  1  SPI data out
// - spi_cs    out  1  chip select, active low
// - spi_miso  in   1  SPI data in; double-flopped internally
// BEHAVIOUR
// - Interface: reset_n async, active-low; clock clk; all outputs registered.
// - Reset values: spi_cs=1, spi_sclk=0, spi_mosi=0, tx_ready=0, busy=0, rx_valid=0, rx_data=0, FSM=IDLE.
// - Reset asserted mid-frame aborts immediately. CS rises asynchronously; no partial byte is completed.
// - States:
//   - IDLE: tx_ready=1.
//   - SETUP: CS low, count CS_SETUP.
//   - SHIFT: 8 bits.
//   - WAIT_NEXT: CS low, tx_ready=1.
//   - HOLD: CS low, count CS_HOLD.
//   - GAP: CS high, count CS_HOLD.
// - IDLE: on accept, latch tx_data/tx_last into shift reg, drive CS low next clk -> SETUP.
// - SETUP -> SHIFT after CS_SETUP cycles.
// - SHIFT, per bit: SCLK rises and MOSI updates to the next bit on the same clk edge.
//   - CLK_DIV cycles later SCLK falls; MISO is sampled from the sync reg on that edge.
//   - CLK_DIV cycles later the next bit starts.
//   - Bit period is 2*CLK_DIV; a byte is 16*CLK_DIV clk cycles.
// - After the 8th falling edge:
//   - if latched last=0 -> WAIT_NEXT;
//   - else -> HOLD.
//   - rx_valid pulses on the cycle after that edge.
// - WAIT_NEXT: SCLK low, CS low.
//   - An accept there starts the next byte after CLK_DIV cycles (no CS_SETUP).
//   - With no tx_valid the FSM waits indefinitely with CS held low.
// - HOLD -> GAP: CS rises on GAP entry. GAP -> IDLE after CS_HOLD cycles.
//   - The minimum CS-high time is guaranteed before the next frame.
// - tx_ready is combinational on state only; it never depends on tx_valid.
// - tx_ready=0 in SETUP, SHIFT, HOLD and GAP; tx_valid is ignored there.
// - Counters:
//   - phase counter width $clog2(max(CLK_DIV,CS_SETUP,CS_HOLD)+1);
//   - bit counter 3 bits, wraps 7->0 only at byte end.
// - A 1-byte frame with tx_last=1 is legal. tx_last is sampled only at accept.
// CONFIGURATION
// - SPI_READBACK_EN defined: MISO 2-FF sync, 8-bit capture shift reg; rx_valid/rx_data behave as above.
// - SPI_READBACK_EN undefined: no MISO logic; rx_valid=0 and rx_data=0 constant; spi_miso unused (lint waiver).
// TESTING
// - Reset: hold reset_n=0 -> spi_cs=1, spi_sclk=0, spi_mosi=0, busy=0, tx_ready=1 after release.
// - Single byte, CLK_DIV=4: send 0xA5 last=1.
//   - CS falls 1 clk after accept; first SCLK rise 2 clk later.
//   - 8 rises spaced 8 clk; MOSI 1,0,1,0,0,1,0,1 stable across each fall.
//   - CS rises 2 clk after the 8th fall; tx_ready=1 again 2 clk after that.
// - Burst 0x01,0x02,0x03 (last on 0x03), tx_valid held high -> CS stays low across all 24 SCLK rises, no CS glitch.
// - Stall: send 0x10 last=0, withhold tx_valid 500 clk -> CS low, SCLK low throughout; then send 0x20 last=1 -> 8 more rises, CS rises.
// - Readback (SPI_READBACK_EN): slave model drives MISO 0x3C on rising edges -> rx_valid pulses once, rx_data=0x3C.
// - Reset mid-frame: assert reset_n=0 after the 3rd SCLK rise -> CS=1, SCLK=0 immediately; next frame 0x55 transmits cleanly from bit 7.

Source files
------------

// File: rtl/spi_command_master.sv
// spi_command_master: CPOL=0 / CPHA=1 SPI initiator sending byte-stream command frames, MSB first.
// Define SPI_READBACK_EN to build the MISO synchroniser and readback capture path.
module spi_command_master #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       spi_sclk,
   output logic       spi_mosi,
   output logic       spi_cs,
   input  logic       spi_miso
);
   localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int unsigned MAX_CNT = (MAX_A > CS_HOLD) ? MAX_A : CS_HOLD;
   localparam int unsigned PW      = $clog2(MAX_CNT + 1);
   localparam logic [PW-1:0] DIV_END   = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] SETUP_END = PW'(CS_SETUP - 1);
   localparam logic [PW-1:0] HOLD_END  = PW'(CS_HOLD - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SETUP, ST_SHIFT, ST_WAIT_NEXT, ST_HOLD, ST_GAP
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            last_q, last_d;
   logic            sclk_q, sclk_d;
   logic            mosi_q, mosi_d;
   logic            cs_q, cs_d;
   logic            ready_q, ready_d;
   logic            busy_q, busy_d;
   logic            accept;
   logic            sample_miso;
   logic            byte_done;

   assign accept = tx_valid && ready_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         last_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_q    <= 1'b1;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_q    <= cs_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + PW'(1);
      bit_d       = bit_q;
      shift_d     = shift_q;
      last_d      = last_q;
      sclk_d      = sclk_q;
      mosi_d      = mosi_q;
      cs_d        = cs_q;
      sample_miso = 1'b0;
      byte_done   = 1'b0;
      case (state_q)
         ST_IDLE, ST_WAIT_NEXT: begin
            cnt_d = '0;
            if (accept) begin
               shift_d = tx_data;
               last_d  = tx_last;
               cs_d    = 1'b0;
               // Continuation bytes skip CS setup and enter the low half of a bit period.
               state_d = (state_q == ST_IDLE) ? ST_SETUP : ST_SHIFT;
            end
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_END) begin
               cnt_d   = '0;
               sclk_d  = 1'b1;
               mosi_d  = shift_q[7];
               shift_d = {shift_q[6:0], 1'b0};
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == DIV_END) begin
               cnt_d = '0;
               if (sclk_q) begin
                  sclk_d      = 1'b0;
                  sample_miso = 1'b1;
                  if (bit_q == 3'd7) begin
                     bit_d     = '0;
                     byte_done = 1'b1;
                     state_d   = last_q ? ST_HOLD : ST_WAIT_NEXT;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  sclk_d  = 1'b1;
                  mosi_d  = shift_q[7];
                  shift_d = {shift_q[6:0], 1'b0};
               end
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_END) begin
               cnt_d   = '0;
               cs_d    = 1'b1;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (cnt_q == HOLD_END) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_NEXT);
      busy_d  = (state_d != ST_IDLE);
   end

   assign tx_ready = ready_q;
   assign busy     = busy_q;
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign spi_cs   = cs_q;

`ifdef SPI_READBACK_EN
   logic       miso_s1_q, miso_s2_q;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         miso_s1_q  <= 1'b0;
         miso_s2_q  <= 1'b0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         miso_s1_q  <= spi_miso;
         miso_s2_q  <= miso_s1_q;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   always_comb begin
      rx_shift_d = sample_miso ? {rx_shift_q[6:0], miso_s2_q} : rx_shift_q;
      rx_data_d  = byte_done ? {rx_shift_q[6:0], miso_s2_q} : rx_data_q;
      rx_valid_d = byte_done;
   end

   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
`else
   logic unused_readback;
   assign unused_readback = ^{spi_miso, sample_miso, byte_done};
   assign rx_valid = 1'b0;
   assign rx_data  = '0;
`endif

endmodule

// File: tb/tb_spi_command_master.sv
// Directed self-checking bench for spi_command_master at CLK_DIV=4, CS_SETUP=2, CS_HOLD=2.
module tb_spi_command_master;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_last = 1'b0;
   logic       spi_miso = 1'b0;
   logic       tx_ready, rx_valid, busy, spi_sclk, spi_mosi, spi_cs;
   logic [7:0] rx_data;

   int checks = 0;
   int passes = 0;

   spi_command_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut (
      .clk(clk), .reset_n(reset_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_data(tx_data), .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data),
      .busy(busy), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
      .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   // Bus monitor: counts edges and reassembles MOSI bytes sampled after each SCLK fall.
   int         rise_cnt = 0;
   int         cs_rise_cnt = 0;
   int         rx_pulses = 0;
   logic [7:0] rx_last = '0;
   logic [7:0] mon_sr = '0;
   int         mon_bits = 0;
   logic [7:0] mon_q[$];
   logic       prev_sclk = 1'b0;
   logic       prev_cs = 1'b1;

   always @(negedge clk) begin
      if (!prev_sclk && spi_sclk) rise_cnt++;
      if (prev_sclk && !spi_sclk) begin
         mon_sr = {mon_sr[6:0], spi_mosi};
         mon_bits++;
         if (mon_bits == 8) begin
            mon_q.push_back(mon_sr);
            mon_bits = 0;
         end
      end
      if (spi_cs) mon_bits = 0;
      if (!prev_cs && spi_cs) cs_rise_cnt++;
      if (rx_valid) begin
         rx_pulses++;
         rx_last = rx_data;
      end
      prev_sclk = spi_sclk;
      prev_cs   = spi_cs;
   end

   // CPHA=1 slave: presents the next MISO bit on each SCLK rise.
   logic [7:0] slave_byte = 8'h3C;
   int         sl_idx = 0;
   always @(posedge spi_sclk) begin
      if (!spi_cs && sl_idx < 8) begin
         spi_miso = slave_byte[7 - sl_idx];
         sl_idx++;
      end
   end
   always @(posedge spi_cs) sl_idx = 0;

   task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
      logic acc;
      ok = 0;
      tx_data  = d;
      tx_last  = l;
      tx_valid = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         acc = tx_ready;
         @(negedge clk);
         if (acc) begin
            ok = 1;
            break;
         end
      end
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int i = 0; i < 5000; i++) begin
         if (!busy) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (spi_cs !== 1'b1) $display("FAIL reset_cs got %b want 1", spi_cs); else passes++;
      checks++; if (spi_sclk !== 1'b0) $display("FAIL reset_sclk got %b want 0", spi_sclk); else passes++;
      checks++; if (spi_mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", spi_mosi); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
      checks++; if (tx_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", tx_ready); else passes++;
      checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", rx_valid); else passes++;
      checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data); else passes++;
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (tx_ready !== 1'b1) $display("FAIL release_ready got %b want 1", tx_ready); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL release_busy got %b want 0", busy); else passes++;
      checks++; if (spi_cs !== 1'b1) $display("FAIL release_cs got %b want 1", spi_cs); else passes++;
   endtask

   task automatic test_single_byte;
      logic [7:0] b;
      logic       exp_sclk, exp_cs, exp_ready, exp_mosi;
      int         base_rx;
      b = 8'hA5;
      base_rx = rx_pulses;
      tx_data = b; tx_last = 1'b1; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      // t counts clk edges after the accepting edge
      for (int t = 0; t < 70; t++) begin
         exp_sclk  = (t >= 2 && t <= 61 && ((t - 2) % 8) < 4);
         exp_cs    = (t >= 64);
         exp_ready = (t >= 66);
         checks++; if (spi_sclk !== exp_sclk) $display("FAIL single_sclk t=%0d got %b want %b", t, spi_sclk, exp_sclk); else passes++;
         checks++; if (spi_cs !== exp_cs) $display("FAIL single_cs t=%0d got %b want %b", t, spi_cs, exp_cs); else passes++;
         checks++; if (tx_ready !== exp_ready) $display("FAIL single_ready t=%0d got %b want %b", t, tx_ready, exp_ready); else passes++;
         checks++; if (busy !== !exp_ready) $display("FAIL single_busy t=%0d got %b want %b", t, busy, !exp_ready); else passes++;
         if (t >= 2 && t <= 61) begin
            exp_mosi = b[7 - (t - 2) / 8];
            checks++; if (spi_mosi !== exp_mosi) $display("FAIL single_mosi t=%0d got %b want %b", t, spi_mosi, exp_mosi); else passes++;
         end
         @(negedge clk);
      end
`ifndef SPI_READBACK_EN
      checks++; if (rx_pulses - base_rx !== 0) $display("FAIL single_rx_quiet got %0d pulses want 0", rx_pulses - base_rx); else passes++;
`endif
   endtask

   task automatic test_back_to_back;
      logic [7:0] bb[3];
      logic       acc;
      int         idx, base_rise, base_cs;
      bit         ok;
      bb[0] = 8'h01; bb[1] = 8'h02; bb[2] = 8'h03;
      mon_q.delete();
      base_rise = rise_cnt;
      base_cs   = cs_rise_cnt;
      idx = 0;
      tx_data = bb[0]; tx_last = 1'b0; tx_valid = 1'b1;
      for (int g = 0; g < 5000 && idx < 3; g++) begin
         acc = tx_ready;
         @(negedge clk);
         if (acc) begin
            idx++;
            if (idx < 3) begin
               tx_data = bb[idx];
               tx_last = (idx == 2);
            end else begin
               tx_valid = 1'b0;
            end
         end
      end
      tx_valid = 1'b0;
      checks++; if (idx !== 3) $display("FAIL burst_accepts got %0d want 3", idx); else passes++;
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL burst_idle_timeout got busy want idle"); else passes++;
      checks++; if (rise_cnt - base_rise !== 24) $display("FAIL burst_rises got %0d want 24", rise_cnt - base_rise); else passes++;
      checks++; if (cs_rise_cnt - base_cs !== 1) $display("FAIL burst_cs_rises got %0d want 1", cs_rise_cnt - base_cs); else passes++;
      checks++; if (mon_q.size() !== 3) $display("FAIL burst_bytes got %0d want 3", mon_q.size()); else passes++;
      for (int i = 0; i < 3; i++) begin
         checks++; if (mon_q[i] !== bb[i]) $display("FAIL burst_data%0d got %h want %h", i, mon_q[i], bb[i]); else passes++;
      end
   endtask

   task automatic test_stall;
      int  base_rise, base_cs, viol;
      bit  ok, reached;
      mon_q.delete();
      base_rise = rise_cnt;
      base_cs   = cs_rise_cnt;
      send_byte(8'h10, 1'b0, ok);
      checks++; if (!ok) $display("FAIL stall_accept1 got timeout want accept"); else passes++;
      reached = 0;
      for (int i = 0; i < 2000; i++) begin
         if (busy && tx_ready) begin
            reached = 1;
            break;
         end
         @(negedge clk);
      end
      checks++; if (!reached) $display("FAIL stall_wait_state got timeout want busy&ready"); else passes++;
      viol = 0;
      for (int i = 0; i < 500; i++) begin
         if (spi_cs !== 1'b0 || spi_sclk !== 1'b0) viol++;
         @(negedge clk);
      end
      checks++; if (viol !== 0) $display("FAIL stall_lines got %0d bad cycles want 0", viol); else passes++;
      checks++; if (tx_ready !== 1'b1) $display("FAIL stall_ready got %b want 1", tx_ready); else passes++;
      send_byte(8'h20, 1'b1, ok);
      checks++; if (!ok) $display("FAIL stall_accept2 got timeout want accept"); else passes++;
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL stall_idle_timeout got busy want idle"); else passes++;
      checks++; if (rise_cnt - base_rise !== 16) $display("FAIL stall_rises got %0d want 16", rise_cnt - base_rise); else passes++;
      checks++; if (cs_rise_cnt - base_cs !== 1) $display("FAIL stall_cs_rises got %0d want 1", cs_rise_cnt - base_cs); else passes++;
      checks++; if (mon_q.size() !== 2) $display("FAIL stall_bytes got %0d want 2", mon_q.size()); else passes++;
      checks++; if (mon_q[0] !== 8'h10) $display("FAIL stall_data0 got %h want 10", mon_q[0]); else passes++;
      checks++; if (mon_q[1] !== 8'h20) $display("FAIL stall_data1 got %h want 20", mon_q[1]); else passes++;
   endtask

`ifdef SPI_READBACK_EN
   task automatic test_readback;
      int base_rx;
      bit ok;
      mon_q.delete();
      slave_byte = 8'h3C;
      base_rx = rx_pulses;
      send_byte(8'hC3, 1'b1, ok);
      checks++; if (!ok) $display("FAIL rb_accept got timeout want accept"); else passes++;
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL rb_idle_timeout got busy want idle"); else passes++;
      checks++; if (rx_pulses - base_rx !== 1) $display("FAIL rb_pulses got %0d want 1", rx_pulses - base_rx); else passes++;
      checks++; if (rx_last !== 8'h3C) $display("FAIL rb_data got %h want 3c", rx_last); else passes++;
      checks++; if (mon_q.size() !== 1 || mon_q[0] !== 8'hC3) $display("FAIL rb_mosi got %h want c3", mon_q[0]); else passes++;
   endtask
`endif

   task automatic test_reset_mid_frame;
      int base_rise;
      bit ok, reached;
      base_rise = rise_cnt;
      send_byte(8'hFF, 1'b1, ok);
      checks++; if (!ok) $display("FAIL mid_accept got timeout want accept"); else passes++;
      reached = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         if (rise_cnt - base_rise >= 3) begin
            reached = 1;
            break;
         end
      end
      checks++; if (!reached) $display("FAIL mid_third_rise got timeout want 3 rises"); else passes++;
      checks++; if (spi_sclk !== 1'b1) $display("FAIL mid_sclk_pre got %b want 1", spi_sclk); else passes++;
      reset_n = 1'b0;
      #1;
      checks++; if (spi_cs !== 1'b1) $display("FAIL mid_cs_async got %b want 1", spi_cs); else passes++;
      checks++; if (spi_sclk !== 1'b0) $display("FAIL mid_sclk_async got %b want 0", spi_sclk); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else passes++;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      mon_q.delete();
      base_rise = rise_cnt;
      send_byte(8'h55, 1'b1, ok);
      checks++; if (!ok) $display("FAIL mid_accept2 got timeout want accept"); else passes++;
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL mid_idle_timeout got busy want idle"); else passes++;
      checks++; if (rise_cnt - base_rise !== 8) $display("FAIL mid_rises got %0d want 8", rise_cnt - base_rise); else passes++;
      checks++; if (mon_q.size() !== 1 || mon_q[0] !== 8'h55) $display("FAIL mid_data got %h (n=%0d) want 55", mon_q[0], mon_q.size()); else passes++;
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_stall();
`ifdef SPI_READBACK_EN
      test_readback();
`endif
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
